// File: rtl/audio_i2s_tx.sv
// Mono I2S transmitter: buffers 16-bit samples in a small FIFO and serializes
// each one MSB-first on both channels of a codec-clocked I2S frame.
module audio_i2s_tx #(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_bclk,
   input  logic                          i_daclrck,
   input  logic [DATA_W-1:0]             i_data,
   input  logic                          i_valid,
   input  logic                          i_en,
   input  logic                          i_clr,
   output logic                          o_dacdat,
   output logic [$clog2(FIFO_DEPTH):0]   o_level,
   output logic                          o_full,
   output logic                          o_pop,
   output logic                          o_underrun,
   output logic                          o_overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(DATA_W);

   localparam logic [1:0] S_WAIT  = 2'd0;
   localparam logic [1:0] S_DELAY = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_PAD   = 2'd3;

   logic [2:0]        bclk_sync_q, bclk_sync_d;
   logic [2:0]        lrck_sync_q, lrck_sync_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] hold_q, hold_d, shift_q, shift_d;
   logic [CW-1:0]     bitcnt_q, bitcnt_d;
   logic [1:0]        state_q, state_d;
   logic              dacdat_q, dacdat_d;
   logic              pop_q, pop_d;
   logic              underrun_q, underrun_d, overflow_q, overflow_d;

   logic bfall, lfall, lrise, full, empty, push, pop;
   logic [DATA_W-1:0] rd_data;

   // Bit 0 is the first synchronizer stage; bits 1/2 feed edge detection.
   assign bclk_sync_d = {bclk_sync_q[1:0], i_bclk};
   assign lrck_sync_d = {lrck_sync_q[1:0], i_daclrck};
   assign bfall = bclk_sync_q[2] & ~bclk_sync_q[1];
   assign lfall = lrck_sync_q[2] & ~lrck_sync_q[1];
   assign lrise = ~lrck_sync_q[2] & lrck_sync_q[1];

   assign full    = (level_q == LW'(FIFO_DEPTH));
   assign empty   = (level_q == '0);
   assign pop     = lfall & i_en & ~empty;
   // A pop frees a slot in the same cycle, so a push into a full FIFO survives.
   assign push    = i_valid & (~full | pop);
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d    = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      pop_d      = pop;
      underrun_d = (lfall & i_en & empty) | (underrun_q & ~i_clr);
      overflow_d = (i_valid & full & ~pop) | (overflow_q & ~i_clr);
      hold_d     = lfall ? (pop ? rd_data : '0) : hold_q;
   end

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bitcnt_d = bitcnt_q;
      dacdat_d = dacdat_q;
      // LRCK edges take priority over a coincident BCLK fall (delay slot start).
      if (lfall) begin
         shift_d  = pop ? rd_data : '0;
         bitcnt_d = '0;
         dacdat_d = 1'b0;
         state_d  = S_DELAY;
      end else if (lrise && state_q != S_WAIT) begin
         shift_d  = hold_q;
         bitcnt_d = '0;
         dacdat_d = 1'b0;
         state_d  = S_DELAY;
      end else if (bfall) begin
         case (state_q)
            S_DELAY: begin
               dacdat_d = shift_q[DATA_W-1];
               shift_d  = {shift_q[DATA_W-2:0], 1'b0};
               bitcnt_d = CW'(DATA_W - 1);
               state_d  = S_SHIFT;
            end
            S_SHIFT: begin
               if (bitcnt_q == '0) begin
                  dacdat_d = 1'b0;
                  state_d  = S_PAD;
               end else begin
                  dacdat_d = shift_q[DATA_W-1];
                  shift_d  = {shift_q[DATA_W-2:0], 1'b0};
                  bitcnt_d = bitcnt_q - CW'(1);
               end
            end
            default: dacdat_d = 1'b0;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)
               mem_q[gi] <= '0;
            else if (push && wr_ptr_q == AW'(gi))
               mem_q[gi] <= i_data;
         end
      end
   endgenerate

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         bclk_sync_q <= '0;
         lrck_sync_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         hold_q      <= '0;
         shift_q     <= '0;
         bitcnt_q    <= '0;
         state_q     <= S_WAIT;
         dacdat_q    <= 1'b0;
         pop_q       <= 1'b0;
         underrun_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         bclk_sync_q <= bclk_sync_d;
         lrck_sync_q <= lrck_sync_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         hold_q      <= hold_d;
         shift_q     <= shift_d;
         bitcnt_q    <= bitcnt_d;
         state_q     <= state_d;
         dacdat_q    <= dacdat_d;
         pop_q       <= pop_d;
         underrun_q  <= underrun_d;
         overflow_q  <= overflow_d;
      end
   end

   assign o_dacdat   = dacdat_q;
   assign o_level    = level_q;
   assign o_full     = full;
   assign o_pop      = pop_q;
   assign o_underrun = underrun_q;
   assign o_overflow = overflow_q;
endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Streaming I2S transmitter that feeds processed samples from the DSP chain to the audio codec DAC. It accepts 16-bit samples on a one-cycle valid strobe (driven directly by the DSP `o_done`/`o_data` pair) and buffers them in a small FIFO. Samples are serialized MSB-first on `o_dacdat`, synchronized to the codec-mastered BCLK/DACLRCK. Mono source: each sample is sent on both left and right channels of one frame.

## Interface
- FIFO_DEPTH, 4, sample buffer entries; power of 2, ≥2
- DATA_W, 16, sample width; fixed at 16 for this design
- i_clk  in  1  system clock; must be ≥8× BCLK frequency
- i_rst  in  1  asynchronous, active-high reset
- i_bclk  in  1  codec bit clock, asynchronous to i_clk
- i_daclrck  in  1  codec DAC frame clock, asynchronous; 0 = left, 1 = right
- i_data  in  16  signed sample, two's complement
- i_valid  in  1  one-cycle push strobe for i_data
- i_en  in  1  transmit enable; 0 forces silence, no pops
- i_clr  in  1  clears sticky flags
- o_dacdat  out  1  serial data to codec
- o_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- o_full  out  1  level == FIFO_DEPTH
- o_pop  out  1  one-cycle pulse when a sample is consumed
- o_underrun  out  1  sticky: frame start with empty FIFO
- o_overflow  out  1  sticky: push while full

## Operation
- Reset value of every output and internal register: 0. State = S_WAIT.
- i_bclk and i_daclrck each pass through a 2-flop synchronizer (reset 0), then a third flop for edge detect. bfall = BCLK 1→0; lfall/lrise = LRCK edges, all from synced signals.
- FIFO: push on i_valid when not full; i_valid while full (and no same-cycle pop) → sample dropped, o_overflow=1. Push and pop same cycle when full → both occur, level unchanged. No bypass: pop when empty fails even if push in same cycle (push still stored).
- Frame start = lfall. If i_en=1 and FIFO not empty: pop into hold register, o_pop=1. If i_en=1 and empty: hold=0, o_underrun=1. If i_en=0: hold=0, no pop, no flag.
- lrise (right channel start): reload shift register from the same hold value; no pop.
- State machine:
  - S_WAIT: o_dacdat=0; ignores everything until first lfall (prevents a half frame after reset or an LRCK already high). On lfall → frame-start actions, load shift, → S_DELAY.
  - S_DELAY: I2S one-bit delay slot; o_dacdat=0. On bfall → drive shift[15], bitcnt=15, → S_SHIFT.
  - S_SHIFT: on each bfall shift left, drive next bit; after bit 0 has been driven, next bfall → drive 0, → S_PAD.
  - S_PAD: o_dacdat=0 until next LRCK edge.
  - From S_DELAY/S_SHIFT/S_PAD: any LRCK edge → reload shift (pop on lfall), → S_DELAY, aborting a partial word (short frames tolerated).
- LRCK edge and bfall in same cycle (normal I2S alignment): LRCK edge wins; bfall consumed as the delay-slot start.
- i_clr clears o_underrun/o_overflow; if a set condition coincides, set wins.
- o_level/o_full update the cycle after push/pop.

## Timing
- o_dacdat is registered; changes 1 i_clk after the synced bfall, i.e. 3–4 i_clk after the physical BCLK fall; stable before the next BCLK rise given the ≥8× ratio.
- Latency push→first bit on wire: determined by frame position; at most one frame plus FIFO occupancy.
- o_pop asserted in the cycle after lfall is detected, for exactly 1 cycle.
- Reset mid-frame: all outputs 0 immediately; after release, silence until the next full left-channel start.

## Test plan
- Reset, FIFO empty, i_en=1, 32-BCLK/channel frames → o_dacdat all 0; o_underrun=1 after first lfall; i_clr → 0.
- Push 0xA5C3, run one frame → left slot bits 1..16 after LRCK fall = 1010010111000011; right slot identical; bit 0 and bits 17–31 = 0; o_pop pulses once.
- Push 0x8000, 0x7FFF, 0x0001 back-to-back → three frames transmit them in order; o_level goes 3→2→1→0.
- Push 5 samples with FIFO_DEPTH=4 and no frames → o_full=1, o_overflow=1, level 4; 5th sample never appears on o_dacdat.
- Hold i_daclrck=1 through reset release, push 0x1234 → no output until the first LRCK fall; then 0x1234 on both channels.
- Cut a frame short: LRCK edge after 8 data bits → word aborted, new word starts with the delay slot; i_en=0 mid-stream → zeros, level unchanged.
